ifetch_unit: RTL and testbench

- Parametrised multicycle instruction-fetch unit for TinyMIPS.
- Issues memory read beats and assembles INSTRW-bit instructions from WIDTH-bit memory data, replacing the datapath's one-hot irwrite byte loading.
- Tracks the fetch PC and hands complete instructions to the controller/datapath over a valid/ready handshake.
- Accepts a redirect input for branches and jumps.

---
 rtl/tinymips_pkg.sv | 19 +
 rtl/ifetch_assemble.sv | 36 +++
 rtl/ifetch_unit.sv | 133 +++++++++++++
 tb/tb_ifetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tinymips_pkg.sv
// Shared TinyMIPS fetch-path definitions: fetch FSM encoding, default instruction
// width and performance counter width (counters exist only with IFETCH_PERF_EN).
package tinymips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } ifetch_state_e;

    localparam int INSTRW_DEFAULT = 32;
    localparam int PERF_W         = 16;

    // Saturating increment: the counters stick at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/ifetch_assemble.sv
// Instruction assembly register: writes one WIDTH-bit lane per accepted beat,
// first beat into the MSBs (big-endian), with a synchronous clear.
module ifetch_assemble
    import tinymips_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int INSTRW = INSTRW_DEFAULT,
    localparam int BEATS  = INSTRW / WIDTH,
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              we_i,
    input  logic [BW-1:0]     beat_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic [INSTRW-1:0] word_o
);

    logic [INSTRW-1:0] word_q;

    // NOTE: the assembly register is reset like any other state here, because the
    // instruction output must read zero out of reset and after an aborted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (clear_i) begin
            word_q <= '0;
        end else if (we_i) begin
            word_q[(BEATS - 1 - int'(beat_i)) * WIDTH +: WIDTH] <= data_i;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/ifetch_unit.sv
// TinyMIPS multicycle instruction fetch: issues WIDTH-bit read beats, assembles an
// INSTRW-bit instruction and offers it on a valid/ready handshake. Optional
// performance counters are built when IFETCH_PERF_EN is defined.
module ifetch_unit
    import tinymips_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               ADDRW    = 8,
    parameter int               INSTRW   = INSTRW_DEFAULT,
    parameter logic [ADDRW-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDRW-1:0]  mem_adr,
    input  logic              mem_ack,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDRW-1:0]  redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [INSTRW-1:0] instr,
    output logic [ADDRW-1:0]  instr_pc,
    output logic              busy
`ifdef IFETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_fetches,
    output logic [PERF_W-1:0] perf_stalls
`endif
);

    localparam int BEATS = INSTRW / WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    ifetch_state_e    state_q, state_d;
    logic [ADDRW-1:0] pc_q, pc_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             asm_we, asm_clear;
    logic             last_beat;

    assign last_beat = (beat_q == BW'(BEATS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            beat_q  <= beat_d;
        end
    end

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        beat_d    = beat_q;
        asm_we    = 1'b0;
        asm_clear = 1'b0;

        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (mem_ack) begin
                    asm_we = 1'b1;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = HOLD;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d    = pc_q + ADDRW'(BEATS);
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything, including a same-cycle ack or handshake.
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            beat_d    = '0;
            state_d   = FETCH;
            asm_we    = 1'b0;
            asm_clear = 1'b1;
        end
    end

    ifetch_assemble #(
        .WIDTH  (WIDTH),
        .INSTRW (INSTRW)
    ) u_assemble (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (asm_clear),
        .we_i    (asm_we),
        .beat_i  (beat_q),
        .data_i  (mem_rdata),
        .word_o  (instr)
    );

    assign mem_req     = (state_q == FETCH);
    assign busy        = (state_q == FETCH);
    assign instr_valid = (state_q == HOLD);
    assign mem_adr     = pc_q + ADDRW'(beat_q);
    assign instr_pc    = pc_q;

`ifdef IFETCH_PERF_EN
    logic [PERF_W-1:0] fetches_q, stalls_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetches_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (instr_valid && instr_ready) fetches_q <= sat_inc(fetches_q);
            if (state_q == FETCH && !mem_ack) stalls_q <= sat_inc(stalls_q);
        end
    end

    assign perf_fetches = fetches_q;
    assign perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: 8-bit and 16-bit beats, PC wrap from 8'hF8,
// stalls, ready back-pressure, redirect and mid-fetch reset.
module tb_ifetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem8  [256];
    logic [15:0] mem16 [256];

    // Instance A: WIDTH=8, RESET_PC=0
    logic        rst_a, ack_a, ready_a, redir_a;
    logic [7:0]  rpc_a, adr_a, ipc_a, rdata_a;
    logic        req_a, valid_a, busy_a;
    logic [31:0] instr_a;
    // Instance B: WIDTH=16
    logic        rst_b, ack_b, ready_b;
    logic [7:0]  adr_b, ipc_b;
    logic [15:0] rdata_b;
    logic        req_b, valid_b, busy_b;
    logic [31:0] instr_b;
    // Instance C: WIDTH=8, RESET_PC=8'hF8
    logic        rst_c, ack_c, ready_c;
    logic [7:0]  adr_c, ipc_c, rdata_c;
    logic        req_c, valid_c, busy_c;
    logic [31:0] instr_c;

    logic        no_redir = 1'b0;
    logic [7:0]  zero_pc  = 8'h00;

`ifdef IFETCH_PERF_EN
    logic [15:0] pf_a, ps_a, pf_b, ps_b, pf_c, ps_c;
`endif

    assign rdata_a = mem8[adr_a];
    assign rdata_b = mem16[adr_b];
    assign rdata_c = mem8[adr_c];

    ifetch_unit #(.WIDTH(8), .ADDRW(8), .INSTRW(32), .RESET_PC(8'h00)) dut_a (
        .clk(clk), .reset(rst_a), .mem_req(req_a), .mem_adr(adr_a), .mem_ack(ack_a),
        .mem_rdata(rdata_a), .redirect_valid(redir_a), .redirect_pc(rpc_a),
        .instr_valid(valid_a), .instr_ready(ready_a), .instr(instr_a), .instr_pc(ipc_a),
        .busy(busy_a)
`ifdef IFETCH_PERF_EN
        , .perf_fetches(pf_a), .perf_stalls(ps_a)
`endif
    );

    ifetch_unit #(.WIDTH(16), .ADDRW(8), .INSTRW(32), .RESET_PC(8'h00)) dut_b (
        .clk(clk), .reset(rst_b), .mem_req(req_b), .mem_adr(adr_b), .mem_ack(ack_b),
        .mem_rdata(rdata_b), .redirect_valid(no_redir), .redirect_pc(zero_pc),
        .instr_valid(valid_b), .instr_ready(ready_b), .instr(instr_b), .instr_pc(ipc_b),
        .busy(busy_b)
`ifdef IFETCH_PERF_EN
        , .perf_fetches(pf_b), .perf_stalls(ps_b)
`endif
    );

    ifetch_unit #(.WIDTH(8), .ADDRW(8), .INSTRW(32), .RESET_PC(8'hF8)) dut_c (
        .clk(clk), .reset(rst_c), .mem_req(req_c), .mem_adr(adr_c), .mem_ack(ack_c),
        .mem_rdata(rdata_c), .redirect_valid(no_redir), .redirect_pc(zero_pc),
        .instr_valid(valid_c), .instr_ready(ready_c), .instr(instr_c), .instr_pc(ipc_c),
        .busy(busy_c)
`ifdef IFETCH_PERF_EN
        , .perf_fetches(pf_c), .perf_stalls(ps_c)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] e;

        for (int i = 0; i < 256; i++) begin
            mem8[i]  = 8'h00;
            mem16[i] = 16'h0000;
        end
        {mem8[0], mem8[1], mem8[2], mem8[3]}           = 32'h00430820;
        {mem8[4], mem8[5], mem8[6], mem8[7]}           = 32'h8C220004;
        {mem8[8'h40], mem8[8'h41], mem8[8'h42], mem8[8'h43]} = 32'h12345678;
        {mem8[8'hF8], mem8[8'hF9], mem8[8'hFA], mem8[8'hFB]} = 32'hDEADBEEF;
        {mem8[8'hFC], mem8[8'hFD], mem8[8'hFE], mem8[8'hFF]} = 32'hCAFEBABE;
        mem16[0] = 16'h0043; mem16[1] = 16'h0820;
        mem16[2] = 16'h8C22; mem16[3] = 16'h0004;

        rst_a = 0; rst_b = 0; rst_c = 0;
        ack_a = 0; ack_b = 0; ack_c = 0;
        ready_a = 0; ready_b = 0; ready_c = 0;
        redir_a = 0; rpc_a = 8'h00;
        repeat (2) cyc();

        // Reset values
        check("rst_req",   req_a,   1'b0);
        check("rst_adr",   adr_a,   8'h00);
        check("rst_valid", valid_a, 1'b0);
        check("rst_instr", instr_a, 32'h0);
        check("rst_ipc",   ipc_a,   8'h00);
        check("rst_busy",  busy_a,  1'b0);
        check("rstc_adr",  adr_c,   8'hF8);
        check("rstc_ipc",  ipc_c,   8'hF8);
`ifdef IFETCH_PERF_EN
        check("rst_pf", pf_a, 16'h0);
        check("rst_ps", ps_a, 16'h0);
`endif

        // A: first fetch with ack held high, consumer not ready
        rst_a = 1; ack_a = 1;
        check("a_idle_req", req_a, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("a_beat_adr", adr_a, 32'(k));
            check("a_beat_req", req_a, 1'b1);
            check("a_beat_busy", busy_a, 1'b1);
        end
        cyc();
        check("a_c5_valid", valid_a, 1'b1);
        check("a_c5_instr", instr_a, 32'h00430820);
        check("a_c5_ipc",   ipc_a,   8'h00);
        check("a_c5_req",   req_a,   1'b0);
        check("a_c5_busy",  busy_a,  1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("a_hold_valid", valid_a, 1'b1);
            check("a_hold_instr", instr_a, 32'h00430820);
            check("a_hold_req",   req_a,   1'b0);
        end

        // Accept; next fetch at pc+4 with one stall cycle on beat 1
        ready_a = 1;
        cyc(); ready_a = 0;
        check("a_f2_adr0", adr_a, 8'h04);
        check("a_f2_valid", valid_a, 1'b0);
        cyc(); check("a_f2_adr1", adr_a, 8'h05); ack_a = 0;
        cyc(); check("a_stall_adr", adr_a, 8'h05); check("a_stall_req", req_a, 1'b1); ack_a = 1;
        cyc(); check("a_f2_adr2", adr_a, 8'h06);
        cyc(); check("a_f2_adr3", adr_a, 8'h07);
        cyc();
        check("a_f2_valid", valid_a, 1'b1);
        check("a_f2_instr", instr_a, 32'h8C220004);
        check("a_f2_ipc",   ipc_a,   8'h04);

        // Redirect during beat 2 of the fetch at 8
        ready_a = 1;
        cyc(); ready_a = 0; check("a_f3_adr0", adr_a, 8'h08);
        cyc(); check("a_f3_adr1", adr_a, 8'h09);
        cyc(); check("a_f3_adr2", adr_a, 8'h0A); redir_a = 1; rpc_a = 8'h40;
        cyc(); redir_a = 0;
        check("a_redir_adr", adr_a, 8'h40);
        check("a_redir_busy", busy_a, 1'b1);
        for (int k = 1; k < 4; k++) begin
            cyc();
            check("a_redir_beat", adr_a, 32'(8'h40 + k));
        end
        cyc();
        check("a_redir_valid", valid_a, 1'b1);
        check("a_redir_instr", instr_a, 32'h12345678);
        check("a_redir_ipc",   ipc_a,   8'h40);

        // Redirect together with ready in HOLD: PC takes redirect_pc
        ready_a = 1; redir_a = 1; rpc_a = 8'h00;
        cyc(); ready_a = 0; redir_a = 0;
        check("a_rr_adr", adr_a, 8'h00);
        check("a_rr_valid", valid_a, 1'b0);
`ifdef IFETCH_PERF_EN
        check("a_pf3", pf_a, 16'd3);
        check("a_ps1", ps_a, 16'd1);
`endif
        cyc(); check("a_rr_adr1", adr_a, 8'h01);
        cyc(); check("a_rr_adr2", adr_a, 8'h02);
        cyc(); check("a_rr_adr3", adr_a, 8'h03);

        // Reset during beat 3 aborts immediately
        rst_a = 0;
        #1;
        check("a_mid_req",   req_a,   1'b0);
        check("a_mid_adr",   adr_a,   8'h00);
        check("a_mid_valid", valid_a, 1'b0);
        check("a_mid_instr", instr_a, 32'h0);
        check("a_mid_ipc",   ipc_a,   8'h00);
        check("a_mid_busy",  busy_a,  1'b0);
`ifdef IFETCH_PERF_EN
        check("a_mid_pf", pf_a, 16'h0);
        check("a_mid_ps", ps_a, 16'h0);
`endif
        cyc(); cyc();
        check("a_mid_hold_valid", valid_a, 1'b0);
        rst_a = 1; ack_a = 0;
        check("a_re_idle", req_a, 1'b0);
        cyc(); check("a_re_adr0", adr_a, 8'h00); check("a_re_req", req_a, 1'b1);
        cyc(); check("a_re_adr0s", adr_a, 8'h00); ack_a = 1;
        cyc(); check("a_re_adr1", adr_a, 8'h01);
        cyc(); check("a_re_adr2", adr_a, 8'h02);
        cyc(); check("a_re_adr3", adr_a, 8'h03);
        cyc();
        check("a_re_valid", valid_a, 1'b1);
        check("a_re_instr", instr_a, 32'h00430820);
        check("a_re_ipc",   ipc_a,   8'h00);
`ifdef IFETCH_PERF_EN
        check("a_re_ps", ps_a, 16'd1);
        check("a_re_pf", pf_a, 16'd0);
`endif

        // B: 16-bit beats
        rst_b = 1; ack_b = 1;
        check("b_idle_req", req_b, 1'b0);
        cyc(); check("b_adr0", adr_b, 8'h00); check("b_req", req_b, 1'b1);
        cyc(); check("b_adr1", adr_b, 8'h01);
        cyc();
        check("b_valid", valid_b, 1'b1);
        check("b_instr", instr_b, 32'h00430820);
        check("b_ipc",   ipc_b,   8'h00);
        ready_b = 1;
        cyc(); ready_b = 0;
        check("b_next_adr", adr_b, 8'h02);

        // C: back-to-back fetches from 8'hF8 with address wrap
        rst_c = 1; ack_c = 1; ready_c = 1;
        check("c_idle_req", req_c, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(); e = 8'hF8 + 8'(k); check("c_f1_adr", adr_c, e);
        end
        cyc();
        check("c_f1_instr", instr_c, 32'hDEADBEEF);
        check("c_f1_ipc",   ipc_c,   8'hF8);
        check("c_f1_valid", valid_c, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(); e = 8'hFC + 8'(k); check("c_f2_adr", adr_c, e);
        end
        cyc();
        check("c_f2_instr", instr_c, 32'hCAFEBABE);
        check("c_f2_ipc",   ipc_c,   8'hFC);
        for (int k = 0; k < 4; k++) begin
            cyc(); check("c_f3_adr", adr_c, 32'(k));
        end
        cyc();
        check("c_f3_instr", instr_c, 32'h00430820);
        check("c_f3_ipc",   ipc_c,   8'h00);
        check("c_f3_valid", valid_c, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
